// File: rtl/des_decrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module   : des_decrypt_iterative
// Purpose  : Iterative DES decryption core; 16 Feistel rounds in K16..K1 order
//            on a shared round datapath, ROUNDS_PER_CYCLE rounds per clock.
// Revision : 1.0
// ============================================================================
module des_decrypt_iterative #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  cipher_ip,
    input  logic [767:0] round_keys,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  text_fp,
    output logic         busy
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $error("des_decrypt_iterative: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_RPC = 5'(ROUNDS_PER_CYCLE);

    // Table entries are 1-based bit positions with bit 1 as the MSB (FIPS 46-3 numbering).
    localparam int c_E_TABLE [0:47] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int c_P_TABLE [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each S-box: 64 four-bit entries, entry (row*16+col) at bits [255-4*idx -: 4].
    localparam logic [255:0] c_SBOX [0:7] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        logic [5:0]  idx;
        x   = '0;
        s   = '0;
        p   = '0;
        b   = '0;
        idx = '0;
        for (int i = 0; i < 48; i++) begin
            x[47-i] = r[32-c_E_TABLE[i]];
        end
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = x[47-6*i -: 6];
            // Row comes from the outer two bits, column from the inner four.
            idx = {b[5], b[0], b[4:1]};
            s[31-4*i -: 4] = c_SBOX[i][255-4*int'(idx) -: 4];
        end
        for (int i = 0; i < 32; i++) begin
            p[31-i] = s[32-c_P_TABLE[i]];
        end
        return p;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_l;
    logic [31:0]        r_r;
    logic [15:0][47:0]  r_keys;
    logic [4:0]         r_cnt;
    logic [4:0]         w_cnt_next;
    logic               w_last;
    logic               w_accept;

    logic [ROUNDS_PER_CYCLE:0][31:0] w_l;
    logic [ROUNDS_PER_CYCLE:0][31:0] w_r;

    assign w_l[0] = r_l;
    assign w_r[0] = r_r;

    // Packed key element n is K(16-n), i.e. the key for decrypt round n+1.
    generate
        for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
            logic [3:0] w_kidx;
            assign w_kidx   = r_cnt[3:0] + 4'(j);
            assign w_l[j+1] = w_r[j];
            assign w_r[j+1] = w_l[j] ^ des_f(w_r[j], r_keys[w_kidx]);
        end
    endgenerate

    assign w_cnt_next = r_cnt + c_RPC;
    assign w_last     = (r_state == S_RUN) && (w_cnt_next == 5'd16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_state_next = in_valid ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_accept = in_valid & in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l       <= '0;
            r_r       <= '0;
            r_keys    <= '0;
            r_cnt     <= '0;
            text_fp   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy      <= (w_state_next == S_RUN);
            out_valid <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_l    <= cipher_ip[63:32];
                r_r    <= cipher_ip[31:0];
                r_keys <= round_keys;
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                r_l   <= w_l[ROUNDS_PER_CYCLE];
                r_r   <= w_r[ROUNDS_PER_CYCLE];
                r_cnt <= w_cnt_next;
                // The final swap is folded into the output ordering.
                if (w_last) begin
                    text_fp <= {w_r[ROUNDS_PER_CYCLE], w_l[ROUNDS_PER_CYCLE]};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_decrypt_iterative
// Purpose  : Directed known-answer bench for des_decrypt_iterative (RPC 1/2/4/16).
// Revision : 1.0
// ============================================================================
module tb_des_decrypt_iterative;

    localparam int IP_T [0:63] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };
    localparam int FP_T [0:63] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };
    localparam int PC1_T [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] ip64(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
        return r;
    endfunction

    function automatic logic [63:0] fp64(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
        return r;
    endfunction

    // K1..K16 packed in encryption order, K1 in the top 48 bits.
    function automatic logic [767:0] ksched(input logic [63:0] k);
        logic [55:0]  cd;
        logic [27:0]  c;
        logic [27:0]  d;
        logic [47:0]  kn;
        logic [767:0] rk;
        cd = '0;
        kn = '0;
        rk = '0;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SH_T[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) kn[47-i] = cd[56-PC2_T[i]];
            rk[767-48*n -: 48] = kn;
        end
        return rk;
    endfunction

    typedef struct {
        logic [63:0] key;
        logic [63:0] cipher;
        logic [63:0] plain;
    } vec_t;

    vec_t vecs [0:3];

    logic         clk = 1'b0;
    logic         rst;
    logic         iv1;
    logic         ivm;
    logic         out_ready;
    logic [63:0]  cipher_ip;
    logic [767:0] round_keys;

    logic         in_ready1;
    logic         out_valid1;
    logic [63:0]  text_fp1;
    logic         busy1;
    logic [2:0]   irm;
    logic [2:0]   ovm;
    logic [2:0]   bzm;
    logic [63:0]  tfm [0:2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    des_decrypt_iterative #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1), .cipher_ip(cipher_ip),
        .round_keys(round_keys), .out_valid(out_valid1), .out_ready(out_ready),
        .text_fp(text_fp1), .busy(busy1));
    des_decrypt_iterative #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(ivm), .in_ready(irm[0]), .cipher_ip(cipher_ip),
        .round_keys(round_keys), .out_valid(ovm[0]), .out_ready(out_ready),
        .text_fp(tfm[0]), .busy(bzm[0]));
    des_decrypt_iterative #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(ivm), .in_ready(irm[1]), .cipher_ip(cipher_ip),
        .round_keys(round_keys), .out_valid(ovm[1]), .out_ready(out_ready),
        .text_fp(tfm[1]), .busy(bzm[1]));
    des_decrypt_iterative #(.ROUNDS_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(ivm), .in_ready(irm[2]), .cipher_ip(cipher_ip),
        .round_keys(round_keys), .out_valid(ovm[2]), .out_ready(out_ready),
        .text_fp(tfm[2]), .busy(bzm[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        cipher_ip  = ip64(vecs[v].cipher);
        round_keys = ksched(vecs[v].key);
    endtask

    // Wait (bounded) for out_valid on the RPC=1 core; returns edges waited, 0 on timeout.
    task automatic wait_out(output int lat, output logic [63:0] res);
        lat = 0;
        res = '0;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (out_valid1) begin
                lat = c;
                res = text_fp1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int v);
        int          lat1;
        logic [63:0] r1;
        int          latm [0:2];
        logic [63:0] rm [0:2];
        int          nexp [0:2];
        nexp = '{8, 4, 1};
        lat1 = 0;
        r1   = '0;
        for (int m = 0; m < 3; m++) begin
            latm[m] = 0;
            rm[m]   = '0;
        end
        load(v);
        out_ready = 1'b1;
        iv1 = 1'b1;
        ivm = 1'b1;
        tick;
        iv1 = 1'b0;
        ivm = 1'b0;
        chk($sformatf("v%0d_busy", v), 64'(busy1), 64'd1);
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (out_valid1 && lat1 == 0) begin
                lat1 = c;
                r1   = text_fp1;
            end
            for (int m = 0; m < 3; m++) begin
                if (ovm[m] && latm[m] == 0) begin
                    latm[m] = c;
                    rm[m]   = tfm[m];
                end
            end
        end
        chk($sformatf("v%0d_lat_rpc1", v), 64'(lat1), 64'd16);
        chk($sformatf("v%0d_pt_rpc1", v), fp64(r1), vecs[v].plain);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("v%0d_lat_m%0d", v, m), 64'(latm[m]), 64'(nexp[m]));
            chk($sformatf("v%0d_pt_m%0d", v, m), fp64(rm[m]), vecs[v].plain);
        end
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic [63:0] snap;
        logic        ok;
        int          nacc;
        int          nout;
        int          acc_cyc [0:3];
        logic        will;

        vecs[0] = '{key: 64'h133457799BBCDFF1, cipher: 64'h85E813540F0AB405, plain: 64'h0123456789ABCDEF};
        vecs[1] = '{key: 64'h0101010101010101, cipher: 64'h8CA64DE9C1B123A7, plain: 64'h0000000000000000};
        vecs[2] = '{key: 64'h0101010101010101, cipher: 64'h95F8A5E5DD31D900, plain: 64'h8000000000000000};
        vecs[3] = '{key: 64'h8001010101010101, cipher: 64'h95A8D72813DAA94D, plain: 64'h0000000000000000};

        rst = 1'b1;
        iv1 = 1'b0;
        ivm = 1'b0;
        out_ready  = 1'b1;
        cipher_ip  = '0;
        round_keys = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready1), 64'd1);
        chk("rst_out_valid", 64'(out_valid1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_text_fp", text_fp1, 64'd0);
        tick;
        rst = 1'b0;
        tick;

        // Known-answer vectors across all unroll factors.
        for (int v = 0; v < 4; v++) run_vec(v);

        // Backpressure: hold completion for 20 cycles while a second block waits.
        load(0);
        out_ready = 1'b0;
        iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        wait_out(lat, res);
        chk("bp_lat", 64'(lat), 64'd16);
        snap = text_fp1;
        iv1 = 1'b1;
        cipher_ip = ip64(vecs[1].cipher);
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (!(out_valid1 && text_fp1 == snap && !in_ready1 && !busy1)) ok = 1'b0;
        end
        chk("bp_hold", 64'(ok), 64'd1);
        iv1 = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("bp_release_ov", 64'(out_valid1), 64'd0);
        tick;
        chk("bp_no_accept", 64'(busy1), 64'd0);
        chk("bp_text_kept", fp64(text_fp1), vecs[0].plain);

        // Back-to-back: four blocks with in_valid held high.
        nacc = 0;
        nout = 0;
        for (int k = 0; k < 4; k++) acc_cyc[k] = 0;
        load(0);
        out_ready = 1'b1;
        iv1 = 1'b1;
        for (int cyc = 0; cyc < 120 && nout < 4; cyc++) begin
            will = iv1 && in_ready1;
            if (out_valid1) begin
                chk($sformatf("b2b_pt%0d", nout), fp64(text_fp1), vecs[nout].plain);
                nout++;
            end
            tick;
            if (will) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 4) load(nacc);
                else iv1 = 1'b0;
            end
        end
        iv1 = 1'b0;
        chk("b2b_count", 64'(nout), 64'd4);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("b2b_gap%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd17);
        end
        tick;
        tick;

        // Key hold: port keys corrupted 3 cycles after acceptance.
        load(0);
        iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        tick;
        tick;
        tick;
        round_keys = '1;
        wait_out(lat, res);
        chk("keyhold_pt", fp64(res), vecs[0].plain);
        chk("keyhold_lat", 64'(lat), 64'd13);
        tick;
        tick;

        // Reset in the middle of a block.
        load(0);
        iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        for (int c = 0; c < 8; c++) tick;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ov", 64'(out_valid1), 64'd0);
        chk("midrst_busy", 64'(busy1), 64'd0);
        chk("midrst_text", text_fp1, 64'd0);
        tick;
        tick;
        rst = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (out_valid1 || busy1) ok = 1'b0;
        end
        chk("midrst_no_ov", 64'(ok), 64'd1);
        load(1);
        iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        wait_out(lat, res);
        chk("postrst_lat", 64'(lat), 64'd16);
        chk("postrst_pt", fp64(res), vecs[1].plain);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
